theta_stage: RTL and testbench
==============================

THETA_STAGE -- requirements
Module: theta_stage

Interface
REQ-001 Parameter THETA_ROT, default 1, rotate-left amount applied to the neighbour column parity; legal range 0..63.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_lane carries a valid lane.
REQ-005 in_ready  output  1  block accepts a lane this cycle.
REQ-006 in_lane  input  64  state lane A[i]; i = x + 5*y, x fastest, i = 0..24.
REQ-007 out_valid  output  1  out_lane carries a valid theta-mixed lane.
REQ-008 out_ready  input  1  consumer accepts out_lane this cycle.
REQ-009 out_lane  output  64  theta result lane A'[i], same ordering as input.
REQ-010 out_last  output  1  high with out_valid when i = 24.
REQ-011 busy  output  1  high whenever state is not LOAD or the lane counter is nonzero.

Function
REQ-012 Transfer occurs on a cycle where valid and ready are both high; no other cycle changes lane counters.
REQ-013 States: LOAD, COMPUTE, EMIT; encoding is binary, 2 bits.
REQ-014 LOAD: in_ready = 1, out_valid = 0; each input transfer writes A[i] to a 25x64 buffer and XORs it into column parity C[i mod 5].
REQ-015 LOAD -> COMPUTE on the transfer of lane 24; lane counter returns to 0.
REQ-016 COMPUTE: exactly one cycle; in_ready = 0, out_valid = 0; registers D[x] = C[(x+4) mod 5] XOR rol(C[(x+1) mod 5], THETA_ROT) for x = 0..4.
REQ-017 Rotation is modulo 64: bits shifted out of bit 63 reappear at bit 0; THETA_ROT = 0 yields C unrotated.
REQ-018 COMPUTE -> EMIT unconditionally; out_valid first asserts 2 cycles after the lane-24 input transfer.
REQ-019 EMIT: out_valid = 1, in_ready = 0, out_lane = A[i] XOR D[i mod 5]; counter advances only on output transfer.
REQ-020 With out_ready low, out_lane, out_last and out_valid hold stable.
REQ-021 EMIT -> LOAD on output transfer of lane 24; C cleared to zero in that same cycle; in_ready = 1 the next cycle.
REQ-022 Throughput: one lane per cycle in each direction; one block every 25 + 1 + 25 cycles with no backpressure.
REQ-023 in_valid during COMPUTE or EMIT is ignored and no data is consumed.

Reset
REQ-024 While rst is high: state = LOAD, lane counters = 0, C = 0, D = 0, out_valid = 0, out_last = 0, in_ready = 0, busy = 0.
REQ-025 rst has priority over every transfer; asserting it mid-LOAD or mid-EMIT discards the partial block, with no further out_valid until a full new block is loaded.
REQ-026 Lane buffer contents need not be reset; out_lane is don't-care while out_valid = 0.

Structure
REQ-027 Shared package holds LANE_W = 64, NUM_LANES = 25, NUM_COLS = 5, the state enum type and the 64-bit lane typedef.
REQ-028 The five D rotations use the existing 64-bit rotate-left sub-module (rol), one instance per column, r_bits tied to THETA_ROT.
REQ-029 Lane index counter and column index (i mod 5) are kept as separate counters; no divider or modulo operator in RTL.

Verification
REQ-030 All-zero block, out_ready = 1 -> 25 outputs all 0x0, out_last only on the 25th, first out_valid 2 cycles after lane 24 input.
REQ-031 A[0] = 0x1, others 0 -> lane 0 = 0x1; lanes 1,6,11,16,21 = 0x1; lanes 4,9,14,19,24 = 0x2; others 0x0.
REQ-032 A[1] = 0x8000_0000_0000_0000, others 0 -> lanes 0,5,10,15,20 = 0x1; lanes 2,7,12,17,22 = 0x8000_0000_0000_0000; lane 1 = 0x8000_0000_0000_0000; others 0x0 (wrap-around check).
REQ-033 Random block with out_ready toggled pseudo-randomly -> outputs match golden model in order, out_lane stable on every stall cycle, in_ready = 0 throughout EMIT.
REQ-034 rst pulsed after 10 output transfers, then new block loaded -> no outputs from old block; new block outputs correct, C not contaminated by old data.
REQ-035 Two back-to-back blocks, in_valid held high -> in_ready rises the cycle after lane-24 output transfer; second block result correct.

Source files
------------

// File: rtl/theta_stage_pkg.sv
// Shared types and sizing for the theta mixing stage.
package theta_stage_pkg;

  localparam int LANE_W     = 64;
  localparam int NUM_LANES  = 25;
  localparam int NUM_COLS   = 5;
  localparam int ROT_W      = 6;
  localparam int LANE_IDX_W = 5;
  localparam int COL_IDX_W  = 3;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_EMIT    = 2'd2
  } state_e;

  // Column to the left, wrapping 0 -> 4; elaboration-time helper only.
  function automatic int col_prev(input int x);
    return (x == 0) ? NUM_COLS - 1 : x - 1;
  endfunction

  // Column to the right, wrapping 4 -> 0; elaboration-time helper only.
  function automatic int col_next(input int x);
    return (x == NUM_COLS - 1) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/theta_stage_if.sv
// Lane streaming interface: input lane handshake and output lane handshake.
interface theta_stage_if;
  import theta_stage_pkg::*;

  logic  in_valid;
  logic  in_ready;
  lane_t in_lane;
  logic  out_valid;
  logic  out_ready;
  lane_t out_lane;
  logic  out_last;

  // Producer/consumer side (drives input lanes, accepts output lanes).
  modport master (
    output in_valid, in_lane, out_ready,
    input  in_ready, out_valid, out_lane, out_last
  );

  // Theta stage side.
  modport slave (
    input  in_valid, in_lane, out_ready,
    output in_ready, out_valid, out_lane, out_last
  );

endinterface

// File: rtl/theta_stage_rol.sv
// 64-bit rotate-left by a run-time amount; r_bits = 0 passes data through.
module rol
  import theta_stage_pkg::*;
(
  input  lane_t            din,
  input  logic [ROT_W-1:0] r_bits,
  output lane_t            dout
);

  // A right shift by the full lane width yields zero, so r_bits = 0 needs no special case.
  assign dout = (din << r_bits) | (din >> (7'(LANE_W) - {1'b0, r_bits}));

endmodule

// File: rtl/theta_stage.sv
// Theta stage: loads 25 lanes while folding column parity, derives the five
// D words in one cycle, then streams A[i] ^ D[i mod 5] back out in order.
module theta_stage
  import theta_stage_pkg::*;
#(
  parameter int unsigned THETA_ROT = 1
) (
  input  logic           clk,
  input  logic           rst,
  theta_stage_if.slave   bus,
  output logic           busy
);

  state_e                state_q, state_d;
  logic [LANE_IDX_W-1:0] lane_q;
  logic [COL_IDX_W-1:0]  col_q;
  lane_t                 lane_buf [NUM_LANES];
  lane_t                 c_q      [NUM_COLS];
  lane_t                 d_q      [NUM_COLS];
  lane_t                 rot_c    [NUM_COLS];
  lane_t                 d_next   [NUM_COLS];
  logic                  in_ready_c, out_valid_c;
  logic                  in_fire, out_fire, last_lane, last_col;

  assign last_lane = (lane_q == LANE_IDX_W'(NUM_LANES - 1));
  assign last_col  = (col_q  == COL_IDX_W'(NUM_COLS - 1));
  assign in_fire   = bus.in_valid  && in_ready_c;
  assign out_fire  = out_valid_c   && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; reset gates both ready and valid low.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready_c = !rst;
        if (bus.in_valid && in_ready_c && last_lane) state_d = S_COMPUTE;
      end
      S_COMPUTE: state_d = S_EMIT;
      S_EMIT: begin
        out_valid_c = !rst;
        if (out_valid_c && bus.out_ready && last_lane) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_valid_c && last_lane;
  assign bus.out_lane  = lane_buf[lane_q] ^ d_q[col_q];
  assign busy          = !rst && ((state_q != S_LOAD) || (lane_q != '0));

  // Lane index and its column (i mod 5) advance together on any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      col_q  <= '0;
    end else if (in_fire || out_fire) begin
      if (last_lane) begin
        lane_q <= '0;
        col_q  <= '0;
      end else begin
        lane_q <= lane_q + 1'b1;
        col_q  <= last_col ? '0 : col_q + 1'b1;
      end
    end
  end

  // Lane storage written during load.
  always_ff @(posedge clk) begin
    // NOTE: the lane buffer is deliberately not reset; its contents are only read after a full load.
    if (in_fire) lane_buf[lane_q] <= bus.in_lane;
  end

  // Column parity: accumulate on load, clear when the final lane leaves.
  always_ff @(posedge clk) begin
    if (rst || (out_fire && last_lane)) begin
      for (int x = 0; x < NUM_COLS; x++) c_q[x] <= '0;
    end else if (in_fire) begin
      c_q[col_q] <= c_q[col_q] ^ bus.in_lane;
    end
  end

  // D[x] = C[x-1] ^ rol(C[x+1], THETA_ROT), one rotator per column.
  for (genvar x = 0; x < NUM_COLS; x++) begin : g_col
    rol u_rol (
      .din    (c_q[col_next(x)]),
      .r_bits (ROT_W'(THETA_ROT)),
      .dout   (rot_c[x])
    );
    assign d_next[x] = c_q[col_prev(x)] ^ rot_c[x];
  end

  // D captured in the single compute cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < NUM_COLS; x++) d_q[x] <= '0;
    end else if (state_q == S_COMPUTE) begin
      for (int x = 0; x < NUM_COLS; x++) d_q[x] <= d_next[x];
    end
  end

endmodule

// File: tb/tb_theta_stage.sv
// Self-checking bench for theta_stage: scoreboard of expected lanes, pushed
// when a block is driven and popped by a monitor on each output transfer.
module tb_theta_stage;
  import theta_stage_pkg::*;

  typedef lane_t blk_t [NUM_LANES];
  typedef struct {
    lane_t lane;
    logic  last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  theta_stage_if bus ();

  theta_stage #(.THETA_ROT(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   out_count = 0;
  int   rise_cyc = -1;
  int   last_out_cyc = -1;
  bit   stall_mode = 1'b0;
  logic ready_level = 1'b0;
  bit   stalled = 1'b0;
  bit   prev_valid = 1'b0;
  lane_t held_lane;
  logic  held_last;
  exp_t  sb [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-ready driver: fixed level or pseudo-random per cycle.
  initial forever begin
    @(negedge clk);
    if (stall_mode) bus.out_ready = 1'($urandom_range(0, 1));
    else            bus.out_ready = ready_level;
  end

  // Monitor/scoreboard: compares each output transfer and stall stability.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) begin
      stalled    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = bus.out_valid;
      if (bus.out_valid) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_during_emit: got %b want 0 at cycle %0d", bus.in_ready, cyc);
        end
        if (stalled) begin
          checks++;
          if (bus.out_lane !== held_lane || bus.out_last !== held_last) begin
            failures++;
            $display("FAIL stall_hold: got lane=%h last=%b want lane=%h last=%b",
                     bus.out_lane, bus.out_last, held_lane, held_last);
          end
        end
        if (bus.out_ready) begin
          stalled = 1'b0;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: got lane=%h with empty scoreboard", bus.out_lane);
          end else begin
            e = sb.pop_front();
            if (bus.out_lane !== e.lane || bus.out_last !== e.last) begin
              failures++;
              $display("FAIL out_lane[%0d]: got lane=%h last=%b want lane=%h last=%b",
                       24 - sb.size() % 25, bus.out_lane, bus.out_last, e.lane, e.last);
            end
          end
          out_count++;
          if (bus.out_last) last_out_cyc = cyc;
        end else begin
          stalled   = 1'b1;
          held_lane = bus.out_lane;
          held_last = bus.out_last;
        end
      end else if (stalled) begin
        checks++;
        failures++;
        $display("FAIL valid_dropped: got out_valid=0 want 1 during stall");
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic lane_t rol_m(input lane_t v, input int s);
    int r;
    r = s % LANE_W;
    if (r == 0) return v;
    return (v << r) | (v >> (LANE_W - r));
  endfunction

  function automatic void theta_model(input blk_t a, output blk_t r);
    lane_t c [NUM_COLS];
    lane_t d [NUM_COLS];
    for (int x = 0; x < 5; x++) c[x] = '0;
    for (int i = 0; i < 25; i++) c[i % 5] ^= a[i];
    for (int x = 0; x < 5; x++) d[x] = c[(x + 4) % 5] ^ rol_m(c[(x + 1) % 5], 1);
    for (int i = 0; i < 25; i++) r[i] = a[i] ^ d[i % 5];
  endfunction

  task automatic push_exp(input blk_t e);
    for (int i = 0; i < 25; i++) sb.push_back('{lane: e[i], last: (i == 24)});
  endtask

  task automatic push_model(input blk_t a);
    blk_t r;
    theta_model(a, r);
    push_exp(r);
  endtask

  // Drives n lanes, waiting (bounded) for in_ready; records sample cycles of first/last transfer.
  task automatic send_block(input blk_t blk, input int n, input bit hold,
                            output int first_cyc, output int last_cyc);
    int waited;
    first_cyc = -1;
    last_cyc  = -1;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_lane  = blk[i];
      waited = 0;
      #1;
      while (bus.in_ready !== 1'b1) begin
        @(negedge clk);
        #1;
        waited++;
        if (waited > 300) begin
          checks++;
          failures++;
          $display("FAIL in_ready_timeout: got no in_ready want 1 for lane %0d", i);
          bus.in_valid = 1'b0;
          return;
        end
      end
      if (i == 0) first_cyc = cyc;
      if (i == n - 1) last_cyc = cyc;
      @(negedge clk);
    end
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int target, input string tag);
    int n = 0;
    while (out_count < target) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: got %0d outputs want %0d", tag, out_count, target);
        return;
      end
    end
  endtask

  task automatic check_sb_empty(input string tag);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_leftover: got %0d pending want 0", tag, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_lane  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got in_ready=%b out_valid=%b out_last=%b busy=%b want all 0",
               bus.in_ready, bus.out_valid, bus.out_last, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b busy=%b want 1 0 0",
               bus.in_ready, bus.out_valid, busy);
    end
  endtask

  task automatic test_zero_block();
    blk_t a, e;
    int f, l, base;
    @(negedge clk);
    ready_level = 1'b1;
    for (int i = 0; i < 25; i++) begin a[i] = '0; e[i] = '0; end
    push_exp(e);
    base = out_count;
    send_block(a, 25, 1'b0, f, l);
    wait_outputs(base + 25, "zero");
    checks++;
    if (rise_cyc - l !== 2) begin
      failures++;
      $display("FAIL first_valid_latency: got %0d cycles want 2", rise_cyc - l);
    end
    check_sb_empty("zero");
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL return_to_load: got in_ready=%b busy=%b want 1 0", bus.in_ready, busy);
    end
  endtask

  task automatic test_single_bit();
    blk_t a, e;
    int f, l, base;
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin a[i] = '0; e[i] = '0; end
    a[0] = 64'h1;
    e[0] = 64'h1;
    for (int y = 0; y < 5; y++) begin
      e[1 + 5 * y] = 64'h1;
      e[4 + 5 * y] = 64'h2;
    end
    push_exp(e);
    base = out_count;
    send_block(a, 25, 1'b0, f, l);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_compute: got %b want 1", busy);
    end
    wait_outputs(base + 25, "single_bit");
    check_sb_empty("single_bit");
  endtask

  task automatic test_wrap();
    blk_t a, e;
    int f, l, base;
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin a[i] = '0; e[i] = '0; end
    a[1] = 64'h8000_0000_0000_0000;
    for (int y = 0; y < 5; y++) begin
      e[5 * y]     = 64'h1;
      e[2 + 5 * y] = 64'h8000_0000_0000_0000;
    end
    e[1] = 64'h8000_0000_0000_0000;
    push_exp(e);
    base = out_count;
    send_block(a, 25, 1'b0, f, l);
    wait_outputs(base + 25, "wrap");
    check_sb_empty("wrap");
  endtask

  task automatic test_random_stall();
    blk_t a;
    int f, l, base;
    @(negedge clk);
    for (int i = 0; i < 25; i++) a[i] = {$urandom(), $urandom()};
    push_model(a);
    base = out_count;
    stall_mode = 1'b1;
    send_block(a, 25, 1'b0, f, l);
    wait_outputs(base + 25, "random_stall");
    stall_mode = 1'b0;
    check_sb_empty("random_stall");
  endtask

  task automatic test_reset_mid();
    blk_t a, b, c;
    int f, l, base;
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      a[i] = {$urandom(), $urandom()};
      b[i] = {$urandom(), $urandom()};
      c[i] = {$urandom(), $urandom()};
    end
    push_model(a);
    base = out_count;
    send_block(a, 25, 1'b0, f, l);
    wait_outputs(base + 10, "reset_mid_emit");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if (out_count !== base + 10) begin
      failures++;
      $display("FAIL reset_emit_count: got %0d outputs want %0d", out_count - base, 10);
    end
    // Partial load of a different block, then reset mid-load.
    send_block(b, 7, 1'b0, f, l);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (out_count !== base + 10) begin
      failures++;
      $display("FAIL reset_no_outputs: got %0d extra outputs want 0", out_count - base - 10);
    end
    push_model(c);
    send_block(c, 25, 1'b0, f, l);
    wait_outputs(base + 35, "reset_new_block");
    check_sb_empty("reset_new_block");
  endtask

  task automatic test_back_to_back();
    blk_t a, b;
    int fa, la, fb, lb, base, a_last;
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      a[i] = {$urandom(), $urandom()};
      b[i] = {$urandom(), $urandom()};
    end
    push_model(a);
    push_model(b);
    base = out_count;
    send_block(a, 25, 1'b1, fa, la);
    send_block(b, 25, 1'b0, fb, lb);
    a_last = last_out_cyc;
    checks++;
    if (fb - a_last !== 1) begin
      failures++;
      $display("FAIL back_to_back_ready: got %0d cycles want 1", fb - a_last);
    end
    wait_outputs(base + 50, "back_to_back");
    check_sb_empty("back_to_back");
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_single_bit();
    test_wrap();
    test_random_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
